// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
//
// Sequenced reset generator. One asynchronous active-low board reset fans out
// to NUM_CH active-low channel resets. Every channel asserts asynchronously
// and together. The channels then release synchronously, in ascending order:
//   - the board reset first passes through a SYNC_STAGES-deep synchroniser,
//   - channel 0 releases MIN_HOLD cycles after the synchroniser releases,
//   - each following channel releases CH_GAP cycles after the previous one.
// A synchronous software reset request restarts the hold/release sequence
// without re-running the synchroniser. The block also reports the cause of
// the last reset and counts accepted software resets.
//
// Ports
//   clk           system clock
//   async_in_rst  board reset, asynchronous assert, active-low
//   sw_rst_req    software reset request, active-high, sampled on rising clk
//   ch_rst_n      per-channel reset, active-low, bit 0 releases first
//   rst_done      high once every channel is released
//   rst_cause     cause of the last reset: 2'b01 pin, 2'b10 software
//   sw_rst_cnt    accepted software resets, saturating at 255
// -----------------------------------------------------------------------------
module reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int MIN_HOLD    = 8,
  parameter int CH_GAP      = 4
) (
  input  logic              clk,
  input  logic              async_in_rst,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              rst_done,
  output logic [1:0]        rst_cause,
  output logic [7:0]        sw_rst_cnt
);

  // Count value at which the last channel releases; the counter stops there,
  // so it is sized to hold exactly this value and never wraps.
  localparam int LAST_REL = MIN_HOLD + (NUM_CH - 1) * CH_GAP;
  localparam int CNT_W    = $clog2(LAST_REL + 1);

  localparam logic [1:0] CAUSE_PIN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nx;
  logic [CNT_W-1:0]       cnt_inc;
  logic [NUM_CH-1:0]      ch_nx;
  logic                   done_nx;
  logic [1:0]             cause_nx;
  logic [7:0]             sw_cnt_nx;
  logic                   sw_take;

  // Counter value on which channel k is released.
  function automatic logic [CNT_W-1:0] rel_at(input int k);
    return CNT_W'(MIN_HOLD + k * CH_GAP);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Synchroniser: cleared asynchronously, fills with ones once the board
  // reset is released. The last stage is the synchronised reset.
  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // True on the edge at which the synchronised reset rises, so the FSM leaves
  // SYNC on that same edge rather than one cycle later.
  assign sync_rise = sync_chain[SYNC_STAGES-2] & ~sync_chain[SYNC_STAGES-1];

  assign cnt_inc = cnt + CNT_W'(1);

  // Software requests only count once the synchroniser has released.
  assign sw_take = sw_rst_req && (state != SYNC);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ch_nx     = ch_rst_n;
    done_nx   = rst_done;
    cause_nx  = rst_cause;
    sw_cnt_nx = sw_rst_cnt;

    if (sw_take) begin
      state_nx  = HOLD;
      cnt_nx    = '0;
      ch_nx     = '0;
      done_nx   = 1'b0;
      cause_nx  = CAUSE_SW;
      sw_cnt_nx = sat_inc8(sw_rst_cnt);
    end else begin
      case (state)
        SYNC: begin
          if (sync_rise) begin
            state_nx = HOLD;
            cnt_nx   = '0;
          end
        end
        HOLD, RELEASE: begin
          cnt_nx = cnt_inc;
          for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_inc == rel_at(k)) begin
              ch_nx[k] = 1'b1;
            end
          end
          if (cnt_inc == CNT_W'(LAST_REL)) begin
            done_nx  = 1'b1;
            state_nx = DONE;
          end else if (cnt_inc == rel_at(0)) begin
            state_nx = RELEASE;
          end
        end
        DONE: begin
          state_nx = DONE;
        end
        default: begin
          state_nx = SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      state <= SYNC;
    end else begin
      state <= state_nx;
    end
  end

  // Channel resets and status are registered and share the asynchronous
  // clear, so assertion reaches the outputs without waiting for a clock.
  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      cnt        <= '0;
      ch_rst_n   <= '0;
      rst_done   <= 1'b0;
      rst_cause  <= CAUSE_PIN;
      sw_rst_cnt <= 8'd0;
    end else begin
      cnt        <= cnt_nx;
      ch_rst_n   <= ch_nx;
      rst_done   <= done_nx;
      rst_cause  <= cause_nx;
      sw_rst_cnt <= sw_cnt_nx;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq
//
// Bench for reset_seq: one instance with default parameters and one with
// SYNC_STAGES=3, NUM_CH=2, MIN_HOLD=1, CH_GAP=1. The reference model counts
// clock edges since the board reset was released and remembers the edge at
// which the current hold started; channel k is expected released once
// MIN_HOLD + k*CH_GAP edges have passed since that start edge.
// -----------------------------------------------------------------------------
module tb_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_async = 1'b0;
  logic       a_sw    = 1'b0;
  logic [3:0] a_ch;
  logic       a_done;
  logic [1:0] a_cause;
  logic [7:0] a_swc;

  logic       b_async = 1'b0;
  logic       b_sw    = 1'b0;
  logic [1:0] b_ch;
  logic       b_done;
  logic [1:0] b_cause;
  logic [7:0] b_swc;

  int tests = 0;
  int fails = 0;

  reset_seq u_a (
    .clk          (clk),
    .async_in_rst (a_async),
    .sw_rst_req   (a_sw),
    .ch_rst_n     (a_ch),
    .rst_done     (a_done),
    .rst_cause    (a_cause),
    .sw_rst_cnt   (a_swc)
  );

  reset_seq #(
    .SYNC_STAGES (3),
    .NUM_CH      (2),
    .MIN_HOLD    (1),
    .CH_GAP      (1)
  ) u_b (
    .clk          (clk),
    .async_in_rst (b_async),
    .sw_rst_req   (b_sw),
    .ch_rst_n     (b_ch),
    .rst_done     (b_done),
    .rst_cause    (b_cause),
    .sw_rst_cnt   (b_swc)
  );

  logic [14:0] a_obs;
  logic [14:0] b_obs;
  assign a_obs = {a_ch, a_done, a_cause, a_swc};
  assign b_obs = {2'b00, b_ch, b_done, b_cause, b_swc};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int         n;      // edges sampled with the board reset released
    int         t0;     // edge at which the current hold started
    logic [1:0] cause;
    int         swc;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.n = 0; r.t0 = 0; r.cause = 2'b01; r.swc = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_edge(input mdl_t m, input logic sw, input int s);
    mdl_t r = m;
    if (r.n >= s && sw) begin
      r.n     = r.n + 1;
      r.t0    = r.n;
      r.cause = 2'b10;
      if (r.swc < 255) r.swc = r.swc + 1;
    end else begin
      r.n = r.n + 1;
      if (r.n == s) r.t0 = s;
    end
    return r;
  endfunction

  function automatic logic [14:0] exp_vec(input mdl_t m, input int s, input int mh,
                                          input int gap, input int nch);
    logic [3:0] ch;
    logic       done;
    ch   = 4'b0000;
    done = (m.n >= s) && (m.n - m.t0 >= mh + (nch - 1) * gap);
    for (int k = 0; k < nch; k++)
      if (m.n >= s && (m.n - m.t0 >= mh + k * gap)) ch[k] = 1'b1;
    return {ch, done, m.cause, 8'(m.swc)};
  endfunction

  mdl_t ma;
  mdl_t mb;

  always @(posedge clk or negedge a_async) begin
    if (!a_async) ma <= mdl_reset();
    else          ma <= mdl_edge(ma, a_sw, 2);
  end

  always @(posedge clk or negedge b_async) begin
    if (!b_async) mb <= mdl_reset();
    else          mb <= mdl_edge(mb, b_sw, 3);
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    a_async = 1'b0; b_async = 1'b0; a_sw = 1'b1; b_sw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (a_obs !== {4'b0000, 1'b0, 2'b01, 8'd0}) begin
        fails++;
        $display("FAIL reset_a: got %h want %h", a_obs, {4'b0000, 1'b0, 2'b01, 8'd0});
      end
      tests++;
      if (b_obs !== {4'b0000, 1'b0, 2'b01, 8'd0}) begin
        fails++;
        $display("FAIL reset_b: got %h want %h", b_obs, {4'b0000, 1'b0, 2'b01, 8'd0});
      end
    end
    a_sw = 1'b0; b_sw = 1'b0;
  endtask

  task automatic test_power_on();
    logic [3:0] ech;
    a_async = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      ech = (i >= 22) ? 4'b1111 : (i >= 18) ? 4'b0111 : (i >= 14) ? 4'b0011 :
            (i >= 10) ? 4'b0001 : 4'b0000;
      tests++;
      if (a_ch !== ech || a_done !== (i >= 22) || a_cause !== 2'b01 || a_swc !== 8'd0) begin
        fails++;
        $display("FAIL power_on E%0d: got ch=%b done=%b cause=%b cnt=%0d want ch=%b done=%b cause=01 cnt=0",
                 i, a_ch, a_done, a_cause, a_swc, ech, (i >= 22));
      end
    end
  endtask

  task automatic test_async_mid();
    a_async = 1'b0;
    @(negedge clk);
    a_async = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    tests++;
    if (a_ch !== 4'b0011) begin
      fails++;
      $display("FAIL async_mid_pre: got ch=%b want 0011", a_ch);
    end
    a_async = 1'b0;
    #1;
    tests++;
    if (a_ch !== 4'b0000 || a_done !== 1'b0) begin
      fails++;
      $display("FAIL async_mid_assert: got ch=%b done=%b want 0000 0", a_ch, a_done);
    end
    @(negedge clk);
    a_async = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      tests++;
      if (a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL async_mid E%0d: got %h want %h", i, a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
    end
  endtask

  task automatic test_glitch();
    #2 a_async = 1'b0;
    #1;
    tests++;
    if (a_ch !== 4'b0000 || a_done !== 1'b0 || a_cause !== 2'b01) begin
      fails++;
      $display("FAIL glitch_assert: got ch=%b done=%b cause=%b want 0000 0 01", a_ch, a_done, a_cause);
    end
    #1 a_async = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      tests++;
      if (a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL glitch E%0d: got %h want %h", i, a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
    end
  endtask

  task automatic test_sw_reset();
    a_sw = 1'b1;
    @(negedge clk);
    a_sw = 1'b0;
    tests++;
    if (a_obs !== {4'b0000, 1'b0, 2'b10, 8'd1}) begin
      fails++;
      $display("FAIL sw_reset_at_er: got %h want %h", a_obs, {4'b0000, 1'b0, 2'b10, 8'd1});
    end
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      tests++;
      if (a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL sw_reset Er+%0d: got %h want %h", j, a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
      if (j == 8) begin
        tests++;
        if (a_ch !== 4'b0001) begin
          fails++;
          $display("FAIL sw_reset_ch0: got ch=%b want 0001", a_ch);
        end
      end
      if (j == 20) begin
        tests++;
        if (a_ch !== 4'b1111 || a_done !== 1'b1) begin
          fails++;
          $display("FAIL sw_reset_all: got ch=%b done=%b want 1111 1", a_ch, a_done);
        end
      end
    end
  endtask

  task automatic test_sw_held_sat();
    a_sw = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (a_ch !== 4'b0000 || a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL sw_held: got %h want %h", a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
    end
    a_sw = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      tests++;
      if (a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL sw_after_held +%0d: got %h want %h", j, a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
    end
    for (int p = 0; p < 260; p++) begin
      a_sw = 1'b1;
      @(negedge clk);
      a_sw = 1'b0;
      @(negedge clk);
      tests++;
      if (a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL sw_pulse %0d: got %h want %h", p, a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
    end
    tests++;
    if (a_swc !== 8'd255) begin
      fails++;
      $display("FAIL sw_cnt_sat: got %0d want 255", a_swc);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] ech;
    b_sw    = 1'b1;
    b_async = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      ech = (i >= 5) ? 2'b11 : (i >= 4) ? 2'b01 : 2'b00;
      tests++;
      if (b_ch !== ech || b_done !== (i >= 5) || b_cause !== 2'b01 || b_swc !== 8'd0) begin
        fails++;
        $display("FAIL sweep E%0d: got ch=%b done=%b cause=%b cnt=%0d want ch=%b done=%b cause=01 cnt=0",
                 i, b_ch, b_done, b_cause, b_swc, ech, (i >= 5));
      end
      if (i == 3) b_sw = 1'b0;
    end
    b_sw = 1'b1;
    @(negedge clk);
    b_sw = 1'b0;
    tests++;
    if (b_obs !== {4'b0000, 1'b0, 2'b10, 8'd1}) begin
      fails++;
      $display("FAIL sweep_sw: got %h want %h", b_obs, {4'b0000, 1'b0, 2'b10, 8'd1});
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (b_obs !== exp_vec(mb, 3, 1, 1, 2)) begin
        fails++;
        $display("FAIL sweep_after_sw: got %h want %h", b_obs, exp_vec(mb, 3, 1, 1, 2));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      a_async = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      b_async = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      a_sw    = ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0;
      b_sw    = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 99) < 2) begin
        #2 a_async = 1'b0; b_async = 1'b0;
        #2 a_async = 1'b1; b_async = 1'b1;
      end
      @(negedge clk);
      tests++;
      if (a_obs !== exp_vec(ma, 2, 8, 4, 4)) begin
        fails++;
        $display("FAIL random_a cyc %0d: got %h want %h", c, a_obs, exp_vec(ma, 2, 8, 4, 4));
      end
      tests++;
      if (b_obs !== exp_vec(mb, 3, 1, 1, 2)) begin
        fails++;
        $display("FAIL random_b cyc %0d: got %h want %h", c, b_obs, exp_vec(mb, 3, 1, 1, 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_async_mid();
    test_glitch();
    test_sw_reset();
    test_sw_held_sat();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
